// File: rtl/shrv_iter.sv
// +----------------------------------------------------------------------------+
// | shrv_iter : multi-cycle variable right shifter (logical/arithmetic),       |
// |             predicated result, valid/ready on both sides.                  |
// | Optional  : SHRV_ITER_EARLY_EXIT_EN - leave SHIFT once data is saturated.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module shrv_iter #(
    parameter int WIDTH   = 8,
    parameter int STEP    = 2,
    parameter int AMTBITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic               pred,
    input  logic [WIDTH-1:0]   i0,
    input  logic [AMTBITS-1:0] amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               o0_enable,
    output logic [WIDTH-1:0]   o0,
    output logic               busy
);

    // Wide enough to hold both the raw amount and the value WIDTH itself.
    localparam int CW = (AMTBITS > $clog2(WIDTH + 1)) ? AMTBITS : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] C_STEP  = CW'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  data_q;
    logic              op_q;
    logic              pred_q;
    logic [CW-1:0]     rem_q;
    logic [WIDTH-1:0]  o0_q;
    logic              o0_en_q;

    logic [CW-1:0]            w_amt_ext;
    logic [CW-1:0]            w_amt_c;
    logic [CW-1:0]            w_step_amt;
    logic [CW-1:0]            w_rem_d;
    logic signed [WIDTH-1:0]  w_ash;
    logic [WIDTH-1:0]         w_lsh;
    logic [WIDTH-1:0]         w_shifted;
    logic                     w_early;

    assign w_amt_ext  = CW'(amt);
    assign w_amt_c    = (w_amt_ext > C_WIDTH) ? C_WIDTH : w_amt_ext;
    assign w_step_amt = (rem_q < C_STEP) ? rem_q : C_STEP;
    assign w_rem_d    = rem_q - w_step_amt;

    // Arithmetic shift kept in its own signed net so the ternary below cannot
    // strip the signedness and silently turn it into a logical shift.
    assign w_ash      = $signed(data_q) >>> w_step_amt;
    assign w_lsh      = data_q >> w_step_amt;
    assign w_shifted  = op_q ? w_ash : w_lsh;

`ifdef SHRV_ITER_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_sat;
    assign w_sat   = op_q ? {WIDTH{data_q[WIDTH-1]}} : {WIDTH{1'b0}};
    assign w_early = (data_q == w_sat);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= 1'b0;
            pred_q  <= 1'b0;
            rem_q   <= '0;
            o0_q    <= '0;
            o0_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q <= i0;
                        op_q   <= op;
                        pred_q <= pred;
                        rem_q  <= w_amt_c;
                        if (!pred || (w_amt_c == '0)) begin
                            state_q <= ST_DONE;
                            o0_q    <= i0;
                            o0_en_q <= pred;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_early) begin
                        state_q <= ST_DONE;
                        o0_q    <= data_q;
                        o0_en_q <= pred_q;
                    end else begin
                        data_q <= w_shifted;
                        rem_q  <= w_rem_d;
                        if (w_rem_d == '0) begin
                            state_q <= ST_DONE;
                            o0_q    <= w_shifted;
                            o0_en_q <= pred_q;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign o0        = o0_q;
    assign o0_enable = o0_en_q;

endmodule

`default_nettype wire

// File: tb/tb_shrv_iter.sv
// +----------------------------------------------------------------------------+
// | tb_shrv_iter : directed self-checking bench for shrv_iter (8/2/4 config).  |
// | Revision     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shrv_iter;

`ifdef SHRV_ITER_EARLY_EXIT_EN
    localparam int LAT_ZERO_SAT = 2;
`else
    localparam int LAT_ZERO_SAT = 4;
`endif

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic       pred;
    logic [7:0] i0;
    logic [3:0] amt;
    logic       out_valid;
    logic       out_ready;
    logic       o0_enable;
    logic [7:0] o0;
    logic       busy;

    int total;
    int bad;
    int lat;
    int seen_valid;
    logic [7:0] held;

    shrv_iter #(.WIDTH(8), .STEP(2), .AMTBITS(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .pred      (pred),
        .i0        (i0),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o0_enable (o0_enable),
        .o0        (o0),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request while idle, accept it, then count edges until out_valid.
    task automatic issue(input logic o, input logic p, input logic [7:0] d,
                         input logic [3:0] a, output int n);
        @(negedge clk);
        op = o; pred = p; i0 = d; amt = a; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] exp_o,
                                 input logic exp_en, input int exp_lat, input int n);
        chk({tag, "_o0"}, {24'd0, o0}, {24'd0, exp_o});
        chk({tag, "_en"}, {31'd0, o0_enable}, {31'd0, exp_en});
        chk({tag, "_lat"}, n, exp_lat);
        handshake();
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; in_valid = 1'b0; op = 1'b0; pred = 1'b0;
        i0 = 8'h00; amt = 4'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_o0", {24'd0, o0}, 32'd0);
        chk("rst_o0_en", {31'd0, o0_enable}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        issue(1'b0, 1'b1, 8'hB4, 4'd3, lat);
        chk("lsr3_busy", {31'd0, busy}, 32'd1);
        chk("lsr3_in_ready", {31'd0, in_ready}, 32'd0);
        expect_result("lsr3", 8'h16, 1'b1, 2, lat);

        issue(1'b1, 1'b1, 8'hB4, 4'd3, lat);
        expect_result("asr3", 8'hF6, 1'b1, 2, lat);

        issue(1'b1, 1'b1, 8'h80, 4'd12, lat);
        expect_result("asr12_clamp", 8'hFF, 1'b1, 4, lat);

        issue(1'b0, 1'b1, 8'h5A, 4'd0, lat);
        expect_result("amt0", 8'h5A, 1'b1, 0, lat);

        issue(1'b0, 1'b0, 8'h5A, 4'd5, lat);
        expect_result("pred0", 8'h5A, 1'b0, 0, lat);

        issue(1'b0, 1'b1, 8'h03, 4'd8, lat);
        expect_result("lsr8_sat", 8'h00, 1'b1, LAT_ZERO_SAT, lat);

        issue(1'b1, 1'b1, 8'h7F, 4'd15, lat);
        expect_result("asr15_pos", 8'h00, 1'b1, 4, lat);

        issue(1'b0, 1'b1, 8'h81, 4'd1, lat);
        expect_result("lsr1", 8'h40, 1'b1, 1, lat);

        issue(1'b1, 1'b1, 8'h9C, 4'd5, lat);
        expect_result("asr5", 8'hFC, 1'b1, 3, lat);

        // Back-pressure: result must hold while a new request waits.
        issue(1'b0, 1'b1, 8'hB4, 4'd2, lat);
        chk("bp_lat", lat, 32'd1);
        held = o0;
        chk("bp_first_o0", {24'd0, held}, 32'h2D);
        op = 1'b0; pred = 1'b1; i0 = 8'h5A; amt = 4'd0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_o0", {24'd0, o0}, {24'd0, held});
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_o0", {24'd0, o0}, 32'h5A);
        handshake();

        // Reset in the middle of a shift.
        @(negedge clk);
        op = 1'b0; pred = 1'b1; i0 = 8'hFF; amt = 4'd8; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_o0", {24'd0, o0}, 32'd0);
        chk("mid_rst_o0_en", {31'd0, o0_enable}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("mid_rst_no_result", seen_valid, 32'd0);

        issue(1'b1, 1'b1, 8'hC0, 4'd4, lat);
        expect_result("post_rst_asr4", 8'hFC, 1'b1, 2, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
